// File: rtl/bp_fe_mem_cmd_arbiter_if.sv
// Bundle of every handshake and data signal around the fetch-side memory command
// arbiter: two requester command/response pairs, the shared memory port and the
// outstanding-command count. The slave modport is the arbiter's view, and the
// master modport is the view of the surrounding requesters and memory.
interface bp_fe_mem_cmd_arbiter_if #(
  parameter int msg_width_p       = 64,
  parameter int max_outstanding_p = 4
);
  localparam int lg_out_lp = $clog2(max_outstanding_p + 1);

  logic [msg_width_p-1:0] cmd0_i;
  logic                   cmd0_v_i;
  logic                   cmd0_ready_o;
  logic [msg_width_p-1:0] cmd1_i;
  logic                   cmd1_v_i;
  logic                   cmd1_ready_o;

  logic [msg_width_p-1:0] mem_cmd_o;
  logic                   mem_cmd_v_o;
  logic                   mem_cmd_ready_i;
  logic [msg_width_p-1:0] mem_resp_i;
  logic                   mem_resp_v_i;
  logic                   mem_resp_yumi_o;

  logic [msg_width_p-1:0] resp0_o;
  logic                   resp0_v_o;
  logic                   resp0_yumi_i;
  logic [msg_width_p-1:0] resp1_o;
  logic                   resp1_v_o;
  logic                   resp1_yumi_i;

  logic [lg_out_lp-1:0]   outstanding_o;

  modport slave (
    input  cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i,
    input  mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    input  resp0_yumi_i, resp1_yumi_i,
    output cmd0_ready_o, cmd1_ready_o,
    output mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
    output resp0_o, resp0_v_o, resp1_o, resp1_v_o,
    output outstanding_o
  );

  modport master (
    output cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i,
    output mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    output resp0_yumi_i, resp1_yumi_i,
    input  cmd0_ready_o, cmd1_ready_o,
    input  mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
    input  resp0_o, resp0_v_o, resp1_o, resp1_v_o,
    input  outstanding_o
  );
endinterface

// File: rtl/bp_fe_mem_cmd_arbiter.sv
// Round-robin arbiter that shares one BedRock memory port between the I$ UCE
// (port 0) and the trace/aux fetch source (port 1). An offered command that is
// not taken is locked until memory accepts it. A small tag FIFO records which
// port issued each command so that in-order responses go back to their issuer.
module bp_fe_mem_cmd_arbiter #(
  parameter int msg_width_p       = 64,
  parameter int max_outstanding_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  bp_fe_mem_cmd_arbiter_if.slave    bus
);
  localparam int lg_out_lp = $clog2(max_outstanding_p + 1);
  localparam int ptr_w     = $clog2(max_outstanding_p);
  localparam logic [lg_out_lp-1:0] max_count = lg_out_lp'(max_outstanding_p);

  typedef enum logic { IDLE, HOLD } state_e;

  state_e                 state_r, state_n;
  logic                   grant_r, grant_n;
  logic                   rr_last_r;
  logic [lg_out_lp-1:0]   count_r;
  logic [ptr_w-1:0]       wptr_r, rptr_r;
  logic [max_outstanding_p-1:0] tag_mem_r;

  logic                   credit, winner, sel, req_v, cmd_v, issue;
  logic                   nonempty, head, pop;
  logic [msg_width_p-1:0] cmd_sel;
  logic                   unsolicited;

  // Arbitration, command-side handshake and next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_n = state_r;
    grant_n = grant_r;
    // Reset is folded in so that the command offer drops immediately when reset is asserted.
    credit  = reset_n_i && (count_r < max_count);
    winner  = (bus.cmd0_v_i && bus.cmd1_v_i) ? ~rr_last_r : bus.cmd1_v_i;
    sel     = (state_r == HOLD) ? grant_r : winner;
    req_v   = (state_r == HOLD) ? (grant_r ? bus.cmd1_v_i : bus.cmd0_v_i)
                                : (bus.cmd0_v_i || bus.cmd1_v_i);
    cmd_v   = credit && req_v;
    issue   = cmd_v && bus.mem_cmd_ready_i;
    cmd_sel = sel ? bus.cmd1_i : bus.cmd0_i;
    unique case (state_r)
      IDLE: if (cmd_v && !bus.mem_cmd_ready_i) begin
        state_n = HOLD;
        grant_n = winner;
      end
      HOLD: if (issue) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response routing from the head of the tag FIFO.
  always_comb begin
    nonempty    = (count_r != '0);
    head        = tag_mem_r[rptr_r];
    pop         = 1'b0;
    unsolicited = bus.mem_resp_v_i && !nonempty;
    if (nonempty)
      pop = bus.mem_resp_v_i && (head ? bus.resp1_yumi_i : bus.resp0_yumi_i);
  end

  assign bus.mem_cmd_o       = cmd_sel;
  assign bus.mem_cmd_v_o     = cmd_v;
  assign bus.cmd0_ready_o    = issue && !sel;
  assign bus.cmd1_ready_o    = issue && sel;
  assign bus.resp0_o         = bus.mem_resp_i;
  assign bus.resp1_o         = bus.mem_resp_i;
  assign bus.resp0_v_o       = nonempty && !head && bus.mem_resp_v_i;
  assign bus.resp1_v_o       = nonempty && head && bus.mem_resp_v_i;
  assign bus.mem_resp_yumi_o = pop;
  assign bus.outstanding_o   = count_r;

  // Control state: FSM, round-robin pointer, outstanding counter and FIFO pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      grant_r   <= 1'b0;
      rr_last_r <= 1'b1;
      count_r   <= '0;
      wptr_r    <= '0;
      rptr_r    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_r <= state_n;
      grant_r <= grant_n;
      if (issue) begin
        rr_last_r <= sel;
        wptr_r    <= wptr_r + ptr_w'(1);
      end
      if (pop) rptr_r <= rptr_r + ptr_w'(1);
      unique case ({issue, pop})
        2'b10:   count_r <= count_r + lg_out_lp'(1);
        2'b01:   count_r <= count_r - lg_out_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag storage: source ID of each issued command, written at the tail.
  // NOTE: storage is not reset; the pointers and counter alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (issue) tag_mem_r[wptr_r] <= sel;
  end

  a_unsolicited_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !unsolicited) else $warning("unsolicited memory response with no command in flight");
  a_count_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(issue && !pop && count_r == max_count)) else $error("outstanding counter overflow");
  a_count_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(pop && count_r == '0)) else $error("outstanding counter underflow");
endmodule

// File: tb/tb_bp_fe_mem_cmd_arbiter.sv
// Directed bench for the fetch-side memory command arbiter. Inputs change just
// after the falling edge and outputs are sampled 1 ns later, well away from the
// rising edge. Expected values are hand-derived for each step.
module tb_bp_fe_mem_cmd_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam logic [W-1:0] c0a = 16'hA0A0;
  localparam logic [W-1:0] c0b = 16'hA1A1;
  localparam logic [W-1:0] c1a = 16'hB1B1;
  localparam logic [W-1:0] c1b = 16'hB2B2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bp_fe_mem_cmd_arbiter_if #(.msg_width_p(W), .max_outstanding_p(N)) bus ();

  bp_fe_mem_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(N)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // NOTE: stimulus uses blocking assignments from the initial block, away from the active edge.
    rst_n = 1'b0;
    bus.cmd0_i = '0; bus.cmd0_v_i = 1'b0;
    bus.cmd1_i = '0; bus.cmd1_v_i = 1'b0;
    bus.mem_cmd_ready_i = 1'b0;
    bus.mem_resp_i = '0; bus.mem_resp_v_i = 1'b0;
    bus.resp0_yumi_i = 1'b0; bus.resp1_yumi_i = 1'b0;

    // Reset state: offers blocked while reset is held.
    cyc();
    bus.cmd0_v_i = 1'b1; bus.cmd0_i = c0a; bus.mem_cmd_ready_i = 1'b1;
    #1;
    check("rst_cmd_v", bus.mem_cmd_v_o, 0);
    check("rst_cmd0_ready", bus.cmd0_ready_o, 0);
    check("rst_outstanding", bus.outstanding_o, 0);

    // Test 1: three commands in flight, then a lock in HOLD, then an async reset.
    cyc();
    rst_n = 1'b1;
    bus.cmd0_v_i = 1'b0; bus.cmd1_v_i = 1'b1; bus.cmd1_i = c1a;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t1_issue_ready1", bus.cmd1_ready_o, 1);
      check("t1_issue_count", bus.outstanding_o, i);
      cyc();
    end
    bus.mem_cmd_ready_i = 1'b0;
    #1;
    check("t1_offer_v", bus.mem_cmd_v_o, 1);
    check("t1_offer_ready1", bus.cmd1_ready_o, 0);
    check("t1_count3", bus.outstanding_o, 3);
    cyc();
    bus.cmd0_v_i = 1'b1; bus.cmd0_i = c0a;
    #1;
    check("t1_hold_cmd", bus.mem_cmd_o, c1a);
    #1;
    rst_n = 1'b0;
    bus.mem_resp_v_i = 1'b1; bus.resp0_yumi_i = 1'b1; bus.resp1_yumi_i = 1'b1;
    #1;
    check("t1_async_cmd_v", bus.mem_cmd_v_o, 0);
    check("t1_async_ready0", bus.cmd0_ready_o, 0);
    check("t1_async_ready1", bus.cmd1_ready_o, 0);
    check("t1_async_count", bus.outstanding_o, 0);
    check("t1_async_resp0_v", bus.resp0_v_o, 0);
    check("t1_async_resp1_v", bus.resp1_v_o, 0);
    check("t1_async_yumi", bus.mem_resp_yumi_o, 0);
    cyc();
    bus.mem_resp_v_i = 1'b0;

    // Test 2: both requesters held, 1-cycle memory; grants alternate starting with port 0.
    cyc();
    rst_n = 1'b1;
    bus.cmd0_v_i = 1'b1; bus.cmd0_i = c0a;
    bus.cmd1_v_i = 1'b1; bus.cmd1_i = c1a;
    bus.mem_cmd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_resp_v_i = (i > 0);
      bus.mem_resp_i   = W'(16'h5000 + i);
      #1;
      check("t2_ready0", bus.cmd0_ready_o, (i % 2 == 0));
      check("t2_ready1", bus.cmd1_ready_o, (i % 2 == 1));
      check("t2_cmd", bus.mem_cmd_o, (i % 2 == 0) ? c0a : c1a);
      check("t2_count", bus.outstanding_o, (i == 0) ? 0 : 1);
      if (i > 0) begin
        check("t2_resp0_v", bus.resp0_v_o, ((i - 1) % 2 == 0));
        check("t2_resp1_v", bus.resp1_v_o, ((i - 1) % 2 == 1));
        check("t2_yumi", bus.mem_resp_yumi_o, 1);
        check("t2_resp_data", ((i - 1) % 2 == 0) ? bus.resp0_o : bus.resp1_o, 16'h5000 + i);
      end
      cyc();
    end
    bus.cmd0_v_i = 1'b0; bus.cmd1_v_i = 1'b0;
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_i = 16'h5005;
    #1;
    check("t2_last_resp0_v", bus.resp0_v_o, 1);
    check("t2_last_resp1_v", bus.resp1_v_o, 0);
    check("t2_idle_cmd_v", bus.mem_cmd_v_o, 0);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t2_drained", bus.outstanding_o, 0);

    // Test 3: port 0 offered with memory stalled; port 1 rises mid-stall and is ignored.
    cyc();
    bus.cmd0_v_i = 1'b1; bus.cmd0_i = c0a; bus.mem_cmd_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.cmd1_v_i = 1'b1; bus.cmd1_i = c1a;
      end
      #1;
      check("t3_hold_v", bus.mem_cmd_v_o, 1);
      check("t3_hold_cmd", bus.mem_cmd_o, c0a);
      check("t3_hold_ready0", bus.cmd0_ready_o, 0);
      cyc();
    end
    bus.mem_cmd_ready_i = 1'b1;
    #1;
    check("t3_grant0_ready0", bus.cmd0_ready_o, 1);
    check("t3_grant0_ready1", bus.cmd1_ready_o, 0);
    cyc();
    bus.cmd0_i = c0b;
    #1;
    check("t3_grant1_ready1", bus.cmd1_ready_o, 1);
    check("t3_grant1_ready0", bus.cmd0_ready_o, 0);
    check("t3_grant1_cmd", bus.mem_cmd_o, c1a);
    cyc();
    bus.cmd0_v_i = 1'b0; bus.cmd1_v_i = 1'b0; bus.mem_cmd_ready_i = 1'b0;
    bus.mem_resp_v_i = 1'b1; bus.resp0_yumi_i = 1'b1; bus.resp1_yumi_i = 1'b1;
    #1;
    check("t3_count2", bus.outstanding_o, 2);
    check("t3_resp_first_port0", bus.resp0_v_o, 1);
    cyc();
    #1;
    check("t3_resp_second_port1", bus.resp1_v_o, 1);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t3_drained", bus.outstanding_o, 0);

    // Test 4: port 1 streams while memory holds responses; credit runs out at 4.
    cyc();
    bus.cmd1_v_i = 1'b1; bus.cmd1_i = c1b; bus.mem_cmd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_issue_ready1", bus.cmd1_ready_o, 1);
      check("t4_issue_count", bus.outstanding_o, i);
      cyc();
    end
    #1;
    check("t4_full_cmd_v", bus.mem_cmd_v_o, 0);
    check("t4_full_ready1", bus.cmd1_ready_o, 0);
    check("t4_full_count", bus.outstanding_o, 4);
    cyc();
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_i = 16'h6000;
    #1;
    check("t4_pop_yumi", bus.mem_resp_yumi_o, 1);
    check("t4_pop_resp1_v", bus.resp1_v_o, 1);
    check("t4_no_bypass_cmd_v", bus.mem_cmd_v_o, 0);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t4_fifth_ready1", bus.cmd1_ready_o, 1);
    check("t4_fifth_count", bus.outstanding_o, 3);
    cyc();
    bus.cmd1_v_i = 1'b0;
    bus.mem_resp_v_i = 1'b1;
    #1;
    check("t4_refull_count", bus.outstanding_o, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_drain_resp1_v", bus.resp1_v_o, 1);
      check("t4_drain_yumi", bus.mem_resp_yumi_o, 1);
      cyc();
    end
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t4_drained", bus.outstanding_o, 0);

    // Test 5: tags 0,1,1 in flight; port 1 stalls its response at the head.
    cyc();
    bus.cmd0_v_i = 1'b1; bus.cmd0_i = c0a;
    #1;
    check("t5_issue0", bus.cmd0_ready_o, 1);
    cyc();
    bus.cmd0_v_i = 1'b0; bus.cmd1_v_i = 1'b1; bus.cmd1_i = c1a;
    #1;
    check("t5_issue1a", bus.cmd1_ready_o, 1);
    cyc();
    #1;
    check("t5_issue1b", bus.cmd1_ready_o, 1);
    cyc();
    bus.cmd1_v_i = 1'b0;
    bus.resp0_yumi_i = 1'b1; bus.resp1_yumi_i = 1'b0;
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_i = 16'h7000;
    #1;
    check("t5_count3", bus.outstanding_o, 3);
    check("t5_head0_resp0_v", bus.resp0_v_o, 1);
    check("t5_head0_resp1_v", bus.resp1_v_o, 0);
    check("t5_head0_yumi", bus.mem_resp_yumi_o, 1);
    cyc();
    bus.mem_resp_i = 16'h7001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_stall_resp1_v", bus.resp1_v_o, 1);
      check("t5_stall_resp0_v", bus.resp0_v_o, 0);
      check("t5_stall_yumi", bus.mem_resp_yumi_o, 0);
      check("t5_stall_count", bus.outstanding_o, 2);
      cyc();
    end
    bus.resp1_yumi_i = 1'b1;
    #1;
    check("t5_release_yumi", bus.mem_resp_yumi_o, 1);
    check("t5_release_data", bus.resp1_o, 16'h7001);
    cyc();
    bus.mem_resp_i = 16'h7002;
    #1;
    check("t5_last_resp1_v", bus.resp1_v_o, 1);
    check("t5_last_yumi", bus.mem_resp_yumi_o, 1);
    check("t5_last_count", bus.outstanding_o, 1);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t5_drained", bus.outstanding_o, 0);

    // Test 6: a response with nothing in flight is never routed or consumed.
    cyc();
    bus.mem_resp_v_i = 1'b1; bus.resp0_yumi_i = 1'b1; bus.resp1_yumi_i = 1'b1;
    #1;
    check("t6_resp0_v", bus.resp0_v_o, 0);
    check("t6_resp1_v", bus.resp1_v_o, 0);
    check("t6_yumi", bus.mem_resp_yumi_o, 0);
    check("t6_unsolicited_flag", dut.unsolicited, 1);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    check("t6_flag_clear", dut.unsolicited, 0);
    check("t6_count", bus.outstanding_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
